image_out_unpacker: RTL and testbench
=====================================

IMAGE_OUT_UNPACKER -- requirements
Module: image_out_unpacker

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, meaning pixels per line; it SHALL be a multiple of 4 and at least 4.
REQ-002 SHALL have parameter V_ACTIVE, default 720, meaning lines per frame; it SHALL be at least 1.
REQ-003 SHALL have port rd_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rd_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port fifo_rd_vld, input, 1 bit: the prefetch FIFO is presenting a valid word.
REQ-006 SHALL have port fifo_rd_data, input, 64 bits: the presented word, holding 4 packed 16-bit pixels.
REQ-007 SHALL have port fifo_rd_en, output, 1 bit: pops the presented word in the same cycle.
REQ-008 SHALL have port pix_ready, input, 1 bit: the downstream sink accepts a pixel.
REQ-009 SHALL have port pix_valid, output, 1 bit: pix_data holds a valid pixel.
REQ-010 SHALL have port pix_data, output, 16 bits: RGB565 pixel.
REQ-011 SHALL have port pix_sof, output, 1 bit: the current pixel is pixel (0,0) of the frame.
REQ-012 SHALL have port pix_eol, output, 1 bit: the current pixel is the last pixel of its line.
REQ-013 SHALL have port pix_eof, output, 1 bit: the current pixel is the last pixel of the frame.
REQ-014 SHALL have port underflow_cnt, output, 16 bits: saturating count of mid-frame starvation cycles.

Function
REQ-015 Pixel transfer SHALL be defined as a cycle with pix_valid=1 and pix_ready=1.
REQ-016 Word format SHALL be lane0=[15:0], lane1=[31:16], lane2=[47:32], lane3=[63:48]; lanes SHALL be emitted in the order 0,1,2,3.
REQ-017 The block SHALL contain a 64-bit hold register, a hold_vld flag and a 2-bit lane index.
REQ-018 fifo_rd_en SHALL be fifo_rd_vld AND NOT rd_rst AND (NOT hold_vld OR (transfer AND lane==3)).
REQ-019 fifo_rd_en SHALL never be asserted while fifo_rd_vld=0.
REQ-020 On fifo_rd_en, the hold register SHALL load fifo_rd_data, hold_vld SHALL become 1 and lane SHALL become 0 on the next edge.
REQ-021 A transfer with lane<3 SHALL increment lane.
REQ-022 A transfer with lane==3 and no pop SHALL clear hold_vld.
REQ-023 A transfer with lane==3 together with a pop SHALL reload the register with no bubble, sustaining 1 pixel/cycle.
REQ-024 pix_valid SHALL equal hold_vld.
REQ-025 pix_data SHALL be the hold-register lane selected by the lane index.
REQ-026 While pix_valid=1 and pix_ready=0, pix_data, pix_sof, pix_eol and pix_eof SHALL remain stable.
REQ-027 Latency SHALL be 1 cycle: a word popped at edge N SHALL have its lane0 pixel visible after edge N.
REQ-028 Counters x_cnt (0..H_ACTIVE-1) and y_cnt (0..V_ACTIVE-1) SHALL advance on each transfer only.
REQ-029 x_cnt SHALL wrap to 0 at H_ACTIVE-1 and increment y_cnt at that point.
REQ-030 y_cnt SHALL wrap to 0 at V_ACTIVE-1 when x_cnt also wraps.
REQ-031 pix_sof SHALL be pix_valid AND x_cnt==0 AND y_cnt==0.
REQ-032 pix_eol SHALL be pix_valid AND x_cnt==H_ACTIVE-1.
REQ-033 pix_eof SHALL be pix_eol AND y_cnt==V_ACTIVE-1.
REQ-034 A state in_frame SHALL be set by a transfer with sof and cleared by a transfer with eof.
REQ-035 When a single-pixel frame makes sof and eof coincide, in_frame SHALL remain 0.
REQ-036 underflow_cnt SHALL increment by 1 in each cycle with in_frame=1, pix_ready=1 and pix_valid=0.
REQ-037 underflow_cnt SHALL saturate at 16'hFFFF.
REQ-038 underflow_cnt SHALL never increment outside a frame.
REQ-039 Counter widths SHALL be clog2 of the respective parameter, minimum 1 bit.

Reset
REQ-040 While rd_rst=1 on an edge, hold_vld, lane, x_cnt, y_cnt, in_frame and underflow_cnt SHALL clear to 0.
REQ-041 During reset, pix_valid, pix_sof, pix_eol, pix_eof and fifo_rd_en SHALL be 0, and pix_data SHALL be 0 (hold register cleared).
REQ-042 Reset asserted mid-word or mid-frame SHALL discard the held word without popping the FIFO.
REQ-043 After reset deasserts, output SHALL resume with the next FIFO word as pixel (0,0).

Verification (H_ACTIVE=8, V_ACTIVE=2 unless noted)
REQ-044 Words 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005 presented back-to-back with pix_ready=1 SHALL produce pix_data 1..8 on 8 consecutive cycles, sof on pixel 1, eol on pixel 8, and fifo_rd_en pulses 4 cycles apart.
REQ-045 With pix_ready toggling 1,0,1,0, each pixel SHALL be held stable while ready=0, and no pop SHALL occur until lane3 transfers.
REQ-046 Feeding 4 words SHALL assert eof only on pixel 16 and return sof on the next frame's first pixel.
REQ-047 Withholding fifo_rd_vld for 5 cycles after pixel 4 with pix_ready=1 SHALL give underflow_cnt=5; the same gap between frames SHALL leave it unchanged.
REQ-048 Asserting rd_rst with lane=2 SHALL give pix_valid=0 with no pop during reset, and the next word SHALL restart at lane0 with sof=1.
REQ-049 Forcing underflow_cnt to 16'hFFFE followed by 3 starvation cycles SHALL hold it at 16'hFFFF.

Source files
------------

// File: rtl/image_out_unpacker.sv
// Unpacks 64-bit FIFO words into a stream of 16-bit RGB565 pixels (lane 0 first)
// and tags each pixel with frame position markers and a starvation counter.
module image_out_unpacker #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    input  logic        fifo_rd_vld,
    input  logic [63:0] fifo_rd_data,
    output logic        fifo_rd_en,
    input  logic        pix_ready,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic [15:0] underflow_cnt
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    logic [63:0]   hold_q, hold_d;
    logic          hold_vld_q, hold_vld_d;
    logic [1:0]    lane_q, lane_d;
    logic [XW-1:0] x_cnt_q, x_cnt_d;
    logic [YW-1:0] y_cnt_q, y_cnt_d;
    logic          in_frame_q, in_frame_d;
    logic [15:0]   underflow_cnt_q, underflow_cnt_d;

    logic transfer;
    logic last_lane;
    logic pop;

    assign transfer  = hold_vld_q & pix_ready;
    assign last_lane = (lane_q == 2'd3);
    // Refill either into an empty holder or in the same cycle the last lane leaves.
    assign pop       = fifo_rd_vld & ~rd_rst & (~hold_vld_q | (transfer & last_lane));

    assign fifo_rd_en    = pop;
    assign pix_valid     = hold_vld_q;
    assign pix_sof       = hold_vld_q & (x_cnt_q == '0) & (y_cnt_q == '0);
    assign pix_eol       = hold_vld_q & (x_cnt_q == X_LAST);
    assign pix_eof       = pix_eol & (y_cnt_q == Y_LAST);
    assign underflow_cnt = underflow_cnt_q;

    always_comb begin
        pix_data = hold_q[15:0];
        case (lane_q)
            2'd0: pix_data = hold_q[15:0];
            2'd1: pix_data = hold_q[31:16];
            2'd2: pix_data = hold_q[47:32];
            2'd3: pix_data = hold_q[63:48];
            default: pix_data = hold_q[15:0];
        endcase
    end

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        lane_d     = lane_q;
        if (pop) begin
            hold_d     = fifo_rd_data;
            hold_vld_d = 1'b1;
            lane_d     = 2'd0;
        end else if (transfer) begin
            if (last_lane) begin
                hold_vld_d = 1'b0;
            end else begin
                lane_d = lane_q + 2'd1;
            end
        end
    end

    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (transfer) begin
            if (x_cnt_q == X_LAST) begin
                x_cnt_d = '0;
                y_cnt_d = (y_cnt_q == Y_LAST) ? '0 : y_cnt_q + 1'b1;
            end else begin
                x_cnt_d = x_cnt_q + 1'b1;
            end
        end
    end

    // End-of-frame wins so a single-pixel frame never leaves in_frame set.
    always_comb begin
        in_frame_d      = in_frame_q;
        underflow_cnt_d = underflow_cnt_q;
        if (transfer) begin
            if (pix_eof) begin
                in_frame_d = 1'b0;
            end else if (pix_sof) begin
                in_frame_d = 1'b1;
            end
        end
        if (in_frame_q && pix_ready && !hold_vld_q && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_d = underflow_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            hold_q          <= '0;
            hold_vld_q      <= 1'b0;
            lane_q          <= 2'd0;
            x_cnt_q         <= '0;
            y_cnt_q         <= '0;
            in_frame_q      <= 1'b0;
            underflow_cnt_q <= '0;
        end else begin
            hold_q          <= hold_d;
            hold_vld_q      <= hold_vld_d;
            lane_q          <= lane_d;
            x_cnt_q         <= x_cnt_d;
            y_cnt_q         <= y_cnt_d;
            in_frame_q      <= in_frame_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

endmodule

// File: tb/tb_image_out_unpacker.sv
// Directed bench for image_out_unpacker with an 8x2 frame and a queue-backed FIFO.
module tb_image_out_unpacker;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        fifo_rd_vld;
    logic [63:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        pix_ready;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic [15:0] underflow_cnt;

    int checks = 0;
    int failures = 0;

    logic [63:0] fifo_q[$];

    logic        o_vld, o_sof, o_eol, o_eof, o_en;
    logic [15:0] o_data, o_ufl;

    image_out_unpacker #(.H_ACTIVE(8), .V_ACTIVE(2)) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .fifo_rd_vld   (fifo_rd_vld),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .pix_ready     (pix_ready),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .pix_eof       (pix_eof),
        .underflow_cnt (underflow_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    function automatic logic [63:0] mk_word(input int base);
        logic [15:0] b;
        b = 16'(base);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    // One clock: drive inputs, sample outputs mid-cycle, then take the edge.
    task automatic cycle(input bit rst_i, input bit rdy, input bit allow);
        bit popped;
        rd_rst       = rst_i;
        pix_ready    = rdy;
        fifo_rd_vld  = allow && (fifo_q.size() > 0);
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 64'h0;
        #1;
        o_vld  = pix_valid;
        o_data = pix_data;
        o_sof  = pix_sof;
        o_eol  = pix_eol;
        o_eof  = pix_eof;
        o_en   = fifo_rd_en;
        o_ufl  = underflow_cnt;
        popped = fifo_rd_en;
        @(posedge rd_clk);
        if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        fifo_q.delete();
        fifo_q.push_back(mk_word(1));
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if ({o_vld, o_sof, o_eol, o_eof, o_en} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 00000", {o_vld, o_sof, o_eol, o_eof, o_en});
        end
        checks++;
        if (o_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_data: got %h required 0000", o_data);
        end
        checks++;
        if (o_ufl !== 16'h0) begin
            failures++;
            $display("FAIL reset_ufl: got %h required 0000", o_ufl);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fifo_q.push_back(64'h0004_0003_0002_0001);
        fifo_q.push_back(64'h0008_0007_0006_0005);
        for (int c = 0; c <= 8; c++) begin
            cycle(1'b0, 1'b1, 1'b1);
            checks++;
            if (o_en !== ((c == 0) || (c == 4))) begin
                failures++;
                $display("FAIL b2b_rd_en c%0d: got %b required %b", c, o_en, (c == 0) || (c == 4));
            end
            if (c >= 1) begin
                checks++;
                if (o_vld !== 1'b1 || o_data !== 16'(c) || o_sof !== (c == 1) || o_eol !== (c == 8) || o_eof !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_pix c%0d: got v=%b d=%h sof=%b eol=%b eof=%b required v=1 d=%h sof=%b eol=%b eof=0",
                             c, o_vld, o_data, o_sof, o_eol, o_eof, 16'(c), c == 1, c == 8);
                end
            end
        end
    endtask

    task automatic test_ready_toggle();
        do_reset();
        fifo_q.push_back(mk_word(1));
        fifo_q.push_back(mk_word(5));
        cycle(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b0, 1'b0, 1'b1);
            checks++;
            if (o_vld !== 1'b1 || o_data !== 16'(k) || o_sof !== (k == 1) || o_en !== 1'b0) begin
                failures++;
                $display("FAIL toggle_hold k%0d: got v=%b d=%h sof=%b en=%b required v=1 d=%h sof=%b en=0",
                         k, o_vld, o_data, o_sof, o_en, 16'(k), k == 1);
            end
            cycle(1'b0, 1'b1, 1'b1);
            checks++;
            if (o_vld !== 1'b1 || o_data !== 16'(k) || o_sof !== (k == 1) || o_en !== (k == 4)) begin
                failures++;
                $display("FAIL toggle_xfer k%0d: got v=%b d=%h sof=%b en=%b required v=1 d=%h sof=%b en=%b",
                         k, o_vld, o_data, o_sof, o_en, 16'(k), k == 1, k == 4);
            end
        end
    endtask

    task automatic test_frame_markers();
        do_reset();
        for (int w = 0; w < 5; w++) fifo_q.push_back(mk_word(4 * w + 1));
        for (int c = 0; c <= 17; c++) begin
            cycle(1'b0, 1'b1, 1'b1);
            checks++;
            if (o_en !== (c % 4 == 0 && c <= 16)) begin
                failures++;
                $display("FAIL frame_rd_en c%0d: got %b required %b", c, o_en, c % 4 == 0 && c <= 16);
            end
            if (c >= 1) begin
                checks++;
                if (o_data !== 16'(c) || o_sof !== (c == 1 || c == 17) || o_eol !== (c == 8 || c == 16) || o_eof !== (c == 16)) begin
                    failures++;
                    $display("FAIL frame_pix c%0d: got d=%h sof=%b eol=%b eof=%b required d=%h sof=%b eol=%b eof=%b",
                             c, o_data, o_sof, o_eol, o_eof, 16'(c), c == 1 || c == 17, c == 8 || c == 16, c == 16);
                end
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        for (int w = 0; w < 4; w++) fifo_q.push_back(mk_word(4 * w + 1));
        for (int c = 0; c <= 27; c++) begin
            cycle(1'b0, 1'b1, !(c >= 4 && c <= 8));
            if (c == 10) begin
                checks++;
                if (o_ufl !== 16'd5 || o_data !== 16'd5) begin
                    failures++;
                    $display("FAIL ufl_mid_frame: got cnt=%0d d=%h required cnt=5 d=0005", o_ufl, o_data);
                end
            end
            if (c == 21) begin
                checks++;
                if (o_eof !== 1'b1 || o_data !== 16'd16) begin
                    failures++;
                    $display("FAIL ufl_eof: got eof=%b d=%h required eof=1 d=0010", o_eof, o_data);
                end
            end
            if (c == 27) begin
                checks++;
                if (o_ufl !== 16'd5 || o_vld !== 1'b0) begin
                    failures++;
                    $display("FAIL ufl_between_frames: got cnt=%0d v=%b required cnt=5 v=0", o_ufl, o_vld);
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        fifo_q.push_back(mk_word(1));
        fifo_q.push_back(mk_word(5));
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (o_data !== 16'd3 || o_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_lane2_entry: got d=%h en=%b required d=0003 en=0", o_data, o_en);
        end
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if ({o_vld, o_sof, o_eol, o_eof, o_en} !== 5'b0 || o_data !== 16'h0) begin
            failures++;
            $display("FAIL rst_lane2_hold: got ctrl=%b d=%h required ctrl=00000 d=0000",
                     {o_vld, o_sof, o_eol, o_eof, o_en}, o_data);
        end
        cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (o_en !== 1'b1 || o_vld !== 1'b0) begin
            failures++;
            $display("FAIL rst_resume_pop: got en=%b v=%b required en=1 v=0", o_en, o_vld);
        end
        cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (o_vld !== 1'b1 || o_data !== 16'd5 || o_sof !== 1'b1) begin
            failures++;
            $display("FAIL rst_resume_sof: got v=%b d=%h sof=%b required v=1 d=0005 sof=1", o_vld, o_data, o_sof);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        fifo_q.push_back(mk_word(1));
        for (int c = 0; c <= 5; c++) cycle(1'b0, 1'b1, 1'b1);
        force dut.underflow_cnt_q = 16'hFFFE;
        cycle(1'b0, 1'b1, 1'b1);
        release dut.underflow_cnt_q;
        #1;
        checks++;
        if (underflow_cnt !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_preload: got %h required fffe", underflow_cnt);
        end
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b1, 1'b1);
            if (c >= 1) begin
                checks++;
                if (o_ufl !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL sat_hold c%0d: got %h required ffff", c, o_ufl);
                end
            end
        end
    endtask

    initial begin
        rd_rst       = 1'b1;
        pix_ready    = 1'b0;
        fifo_rd_vld  = 1'b0;
        fifo_rd_data = 64'h0;
        test_reset();
        test_back_to_back();
        test_ready_toggle();
        test_frame_markers();
        test_underflow();
        test_reset_mid_word();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
